// File: rtl/grant_tenure_ctrl.sv
// grant_tenure_ctrl: turns one-hot arbiter grants into bounded bus tenures.
// The tenure owner's beats are muxed onto dout. A tenure ends on the beat limit
// or on an owner idle timeout. One grant arriving mid-tenure is buffered.
module grant_tenure_ctrl #(
  parameter int DW      = 8,
  parameter int TENURE  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    grant_i,
  input  logic          valid1,
  input  logic          valid2,
  input  logic          valid3,
  input  logic          valid4,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  input  logic [DW-1:0] data3,
  input  logic [DW-1:0] data4,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [3:0]    owner_o,
  output logic          busy_o,
  output logic [3:0]    done_o,
  output logic          err_o,
  output logic          drop_o
);

  localparam int BW = $clog2(TENURE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_XFER, S_REL} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_prev;
  logic [3:0]    r_pending;
  logic [BW-1:0] r_beat;
  logic [IW-1:0] r_idle;

  logic          w_onehot, w_changed, w_event, w_multi;
  logic          w_own_valid, w_xfer_exit;
  logic [DW-1:0] w_own_data;
  logic [3:0]    w_pend_nxt;

  // Grant decode: only a change to a one-hot value starts or queues a tenure.
  assign w_onehot   = (grant_i != 4'd0) && ((grant_i & (grant_i - 4'd1)) == 4'd0);
  assign w_changed  = (grant_i != r_prev);
  assign w_event    = w_changed && w_onehot;
  assign w_multi    = w_changed && (grant_i != 4'd0) && !w_onehot;

  // A grant arriving this cycle overrides whatever is buffered, so the
  // RELEASE decision always sees the newest pending owner.
  assign w_pend_nxt = (w_event && busy_o) ? grant_i : r_pending;

  // Owner's valid/data selection; bit3 is client1.
  assign w_own_valid = |(owner_o & {valid1, valid2, valid3, valid4});

  // Select the owner's data lane.
  always_comb begin
    w_own_data = '0;
    if (owner_o[3])      w_own_data = data1;
    else if (owner_o[2]) w_own_data = data2;
    else if (owner_o[1]) w_own_data = data3;
    else if (owner_o[0]) w_own_data = data4;
  end

  // Exit XFER on the beat reaching TENURE, or the idle cycle reaching TIMEOUT.
  assign w_xfer_exit = w_own_valid ? (r_beat == BW'(TENURE - 1))
                                   : (r_idle == IW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_event) w_state_nxt = S_LOCK;
      S_LOCK:  w_state_nxt = S_XFER;
      S_XFER:  if (w_xfer_exit) w_state_nxt = S_REL;
      S_REL:   w_state_nxt = (w_pend_nxt != 4'd0) ? S_LOCK : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs: busy through LOCK/XFER/RELEASE, done in RELEASE.
  always_comb begin
    busy_o = (r_state != S_IDLE);
    done_o = (r_state == S_REL) ? owner_o : 4'd0;
  end

  // Grant tracking, pending buffer and error/drop pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev    <= 4'd0;
      r_pending <= 4'd0;
      err_o     <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      r_prev    <= grant_i;
      err_o     <= w_multi;
      drop_o    <= w_event && busy_o && (r_pending != 4'd0);
      r_pending <= (r_state == S_REL) ? 4'd0 : w_pend_nxt;
    end
  end

  // Ownership: taken from the grant in IDLE, handed over (or cleared) in RELEASE.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_o <= 4'd0;
    end else if (r_state == S_IDLE && w_event) begin
      owner_o <= grant_i;
    end else if (r_state == S_REL) begin
      owner_o <= w_pend_nxt;
    end
  end

  // Beat/idle counters and the registered data output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_beat     <= '0;
      r_idle     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (r_state == S_LOCK) begin
        r_beat <= '0;
        r_idle <= '0;
      end else if (r_state == S_XFER) begin
        if (w_own_valid) begin
          dout       <= w_own_data;
          dout_valid <= 1'b1;
          r_beat     <= r_beat + BW'(1);
          r_idle     <= '0;
        end else begin
          r_idle <= r_idle + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_grant_tenure_ctrl.sv
// Bench for grant_tenure_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a client-number-level tenure model.
module tb_grant_tenure_ctrl;
  localparam int DW = 8, TENURE = 8, TIMEOUT = 4;
  localparam int P_IDLE = 0, P_LOCK = 1, P_XFER = 2, P_REL = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] grant_i = '0;
  logic valid1 = 0, valid2 = 0, valid3 = 0, valid4 = 0;
  logic [DW-1:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic [DW-1:0] dout;
  logic dout_valid, busy_o, err_o, drop_o;
  logic [3:0] owner_o, done_o;

  int checks = 0, errors = 0;

  grant_tenure_ctrl #(.DW(DW), .TENURE(TENURE), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .grant_i(grant_i),
    .valid1(valid1), .valid2(valid2), .valid3(valid3), .valid4(valid4),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .dout(dout), .dout_valid(dout_valid), .owner_o(owner_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .drop_o(drop_o));

  always #5 clock = ~clock;

  logic [DW+11:0] obs;
  assign obs = {dout, dout_valid, owner_o, busy_o, done_o, err_o, drop_o};

  // Model state: owners are client numbers 1..4, 0 = none.
  logic [3:0]    m_prev = '0;
  int            m_phase = P_IDLE, m_owner = 0, m_pend = 0, m_beats = 0, m_idle = 0;
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 0, m_err = 0, m_drop = 0;

  function automatic int cli(logic [3:0] g);
    case (g)
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return 3;
      4'b0001: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] vec(int n);
    case (n)
      1: return 4'b1000;
      2: return 4'b0100;
      3: return 4'b0010;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DW+11:0] exp_vec();
    logic [3:0] dn;
    dn = (m_phase == P_REL) ? vec(m_owner) : 4'b0000;
    return {m_dout, m_dv, vec(m_owner), (m_phase != P_IDLE), dn, m_err, m_drop};
  endfunction

  task automatic model_step();
    bit ev, ml, bsy, ov;
    int pa;
    logic [DW-1:0] od;
    if (reset) begin
      m_prev = '0; m_phase = P_IDLE; m_owner = 0; m_pend = 0; m_beats = 0;
      m_idle = 0; m_dout = '0; m_dv = 0; m_err = 0; m_drop = 0;
      return;
    end
    ev  = (grant_i != m_prev) && ($countones(grant_i) == 1);
    ml  = (grant_i != m_prev) && ($countones(grant_i) > 1);
    bsy = (m_phase != P_IDLE);
    m_err  = ml;
    m_drop = ev && bsy && (m_pend != 0);
    pa = (ev && bsy) ? cli(grant_i) : m_pend;
    ov = (m_owner == 1) ? valid1 : (m_owner == 2) ? valid2 : (m_owner == 3) ? valid3 : (m_owner == 4) ? valid4 : 1'b0;
    od = (m_owner == 1) ? data1 : (m_owner == 2) ? data2 : (m_owner == 3) ? data3 : data4;
    m_dv = 0;
    case (m_phase)
      P_IDLE: if (ev) begin m_owner = cli(grant_i); m_phase = P_LOCK; end
      P_LOCK: begin m_beats = 0; m_idle = 0; m_phase = P_XFER; end
      P_XFER: begin
        if (ov) begin
          m_dout = od; m_dv = 1; m_beats++; m_idle = 0;
          if (m_beats == TENURE) m_phase = P_REL;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) m_phase = P_REL;
        end
      end
      default: begin
        m_owner = pa;
        m_phase = (pa != 0) ? P_LOCK : P_IDLE;
        pa = 0;
      end
    endcase
    m_pend = pa;
    m_prev = grant_i;
  endtask

  // One clock: model advances on the same edge, outputs settle by +1.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic rand_data();
    data1 = DW'($urandom); data2 = DW'($urandom);
    data3 = DW'($urandom); data4 = DW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; grant_i = '0;
    tick(); tick();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_model got %h exp %h", obs, exp_vec()); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_zero got %h exp 0", obs); end
    reset = 0;
  endtask

  task automatic test_full_tenure();
    logic [DW-1:0] got[$];
    int dones = 0;
    grant_i = 4'b1000; valid1 = 1;
    for (int t = 0; t < 14; t++) begin
      data1 = DW'(t - 1); data2 = DW'($urandom); data3 = DW'($urandom); data4 = DW'($urandom);
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL full_tenure t=%0d got %h exp %h", t, obs, exp_vec()); end
      if (dout_valid) got.push_back(dout);
      if (done_o == 4'b1000) dones++;
    end
    checks++;
    if (got.size() != TENURE) begin errors++; $display("FAIL full_beats got %0d exp %0d", got.size(), TENURE); end
    else for (int i = 0; i < TENURE; i++) begin
      checks++;
      if (got[i] !== DW'(i + 1)) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", i, got[i], DW'(i + 1)); end
    end
    checks++;
    if (dones != 1 || owner_o !== 4'b0000) begin errors++; $display("FAIL full_done got %0d/%b exp 1/0000", dones, owner_o); end
    valid1 = 0;
  endtask

  task automatic test_timeout();
    int beats = 0, done_t = -1;
    grant_i = 4'b0100;
    for (int t = 0; t < 12; t++) begin
      valid2 = (t >= 2 && t < 5); rand_data();
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL timeout t=%0d got %h exp %h", t, obs, exp_vec()); end
      if (dout_valid) beats++;
      if (done_o == 4'b0100) done_t = t;
    end
    checks++;
    if (beats != 3 || done_t != 8) begin errors++; $display("FAIL timeout_rel got beats %0d done@%0d exp 3 @8", beats, done_t); end
    valid2 = 0;
  endtask

  task automatic test_pending_drop();
    int drops = 0, idle_gap = 0;
    bit handoff = 0;
    grant_i = '0; tick();
    valid1 = 1; valid2 = 1; valid3 = 1; valid4 = 1;
    for (int t = 0; t < 24; t++) begin
      grant_i = (t < 3) ? 4'b1000 : (t == 3) ? 4'b0010 : 4'b0001;
      rand_data();
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL pending t=%0d got %h exp %h", t, obs, exp_vec()); end
      if (drop_o) drops++;
      if (t < 20 && !busy_o) idle_gap++;
      if (t == 10 && owner_o == 4'b0001 && busy_o) handoff = 1;
    end
    checks++;
    if (drops != 1 || idle_gap != 0 || !handoff) begin
      errors++; $display("FAIL pending_drop got drops %0d gaps %0d handoff %0d exp 1 0 1", drops, idle_gap, handoff);
    end
    valid1 = 0; valid2 = 0; valid3 = 0; valid4 = 0;
  endtask

  task automatic test_multihot();
    int n = 0;
    grant_i = '0;
    do begin tick(); n++; end while (busy_o && n < 20);
    checks++;
    if (busy_o) begin errors++; $display("FAIL multihot_idle_wait got busy %b exp 0", busy_o); end
    grant_i = 4'b0110; tick();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL multihot got %h exp %h", obs, exp_vec()); end
    checks++;
    if (err_o !== 1'b1 || owner_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++; $display("FAIL multihot_err got err %b owner %b busy %b exp 1 0000 0", err_o, owner_o, busy_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL multihot_pulse got %b exp 0", err_o); end
  endtask

  task automatic test_hold_regrant();
    int starts = 0;
    logic pb = 0;
    grant_i = 4'b1000;
    for (int t = 0; t < 22; t++) begin
      rand_data(); tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL hold t=%0d got %h exp %h", t, obs, exp_vec()); end
      if (busy_o && !pb) starts++;
      pb = busy_o;
    end
    checks++;
    if (starts != 1 || busy_o) begin errors++; $display("FAIL hold_once got starts %0d busy %b exp 1 0", starts, busy_o); end
    grant_i = 4'b0000; tick();
    grant_i = 4'b1000; tick();
    checks++;
    if (busy_o !== 1'b1 || owner_o !== 4'b1000 || obs !== exp_vec()) begin
      errors++; $display("FAIL regrant got busy %b owner %b exp 1 1000", busy_o, owner_o);
    end
  endtask

  task automatic test_reset_mid();
    grant_i = '0;
    for (int i = 0; i < 12; i++) tick();
    grant_i = 4'b0010; valid3 = 1;
    for (int t = 0; t < 5; t++) begin
      rand_data(); tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_mid t=%0d got %h exp %h", t, obs, exp_vec()); end
    end
    reset = 1; tick();
    checks++;
    if (obs !== '0 || obs !== exp_vec()) begin errors++; $display("FAIL reset_mid_clear got %h exp 0", obs); end
    reset = 0; valid3 = 0; grant_i = '0; tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: grant_i = 4'b0000;
          1: grant_i = 4'b0001 << $urandom_range(0, 3);
          default: grant_i = 4'($urandom);
        endcase
      end
      valid1 = ($urandom_range(0, 3) != 0); valid2 = ($urandom_range(0, 3) != 0);
      valid3 = ($urandom_range(0, 2) == 0); valid4 = ($urandom_range(0, 1) == 0);
      rand_data();
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random t=%0d got %h exp %h", t, obs, exp_vec()); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_full_tenure();
    test_timeout();
    test_pending_drop();
    test_multihot();
    test_hold_regrant();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
